// File: rtl/pipe_control_unit.sv
// ---------------------------------------------------------------------------
// pipe_control_unit
//   Decode/EX/WB control for a short in-order pipeline. Decodes the opcode
//   presented in decode and registers the resulting control word into EX.
//   Each word then moves on into WB. mul holds EX for MC_CYCLES cycles. jmp
//   squashes the instruction behind it. Illegal opcodes become bubbles and
//   raise a one-cycle flag.
//
// Parameters
//   OPW        opcode width (3..8)
//   MC_CYCLES  EX-occupancy cycles of mul (1..15)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   instr_valid, opcode  decode-stage instruction
//   stall_in             downstream stall, freezes all pipeline state
//   ex_*                 EX-stage control word (registered)
//   wb_valid/_reg_write  WB-stage control (registered)
//   stall_out            hold fetch/decode (combinational)
//   flush_id             squash the decode-stage instruction (registered pulse)
//   illegal              illegal opcode accepted (registered pulse)
// ---------------------------------------------------------------------------
module pipe_control_unit #(
  parameter int OPW       = 3,
  parameter int MC_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  input  logic [OPW-1:0] opcode,
  input  logic           stall_in,
  output logic           ex_valid,
  output logic [1:0]     ex_alu_ctrl,
  output logic           ex_alu_src,
  output logic           ex_imm_sel,
  output logic           ex_jump,
  output logic           wb_valid,
  output logic           wb_reg_write,
  output logic           stall_out,
  output logic           flush_id,
  output logic           illegal
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MUL   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       imm_sel;
  } ctrl_t;

  localparam ctrl_t C_BUBBLE = ctrl_t'(7'd0);

  // Decoded word; valid=0 doubles as the "illegal" indication.
  function automatic ctrl_t f_decode(input logic [2:0] op3, input logic upper_zero);
    ctrl_t d;
    d = C_BUBBLE;
    if (upper_zero) begin
      case (op3)
        3'b000:  d = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0}; // addi
        3'b001:  d = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0}; // sll
        3'b010:  d = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // add
        3'b011:  d = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1}; // jmp
        3'b100:  d = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0}; // mul
        default: d = C_BUBBLE;
      endcase
    end else begin
      d = C_BUBBLE;
    end
    return d;
  endfunction

  state_e      r_state;
  logic [3:0]  r_cnt;
  ctrl_t       r_ex;
  logic        r_wb_valid;
  logic        r_wb_we;
  logic        r_flush;
  logic        r_illegal;

  state_e      w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  ctrl_t       w_ex_nxt;
  logic        w_wb_valid_nxt;
  logic        w_wb_we_nxt;
  logic        w_flush_nxt;
  logic        w_illegal_nxt;

  logic        w_upper_zero;
  ctrl_t       w_dec;
  logic        w_accept;
  logic        w_is_mul;

  // Upper opcode bits must be zero; the shift form also works when OPW==3.
  assign w_upper_zero = ((opcode >> 3'd3) == {OPW{1'b0}});
  assign w_dec        = f_decode(opcode[2:0], w_upper_zero);
  assign w_accept     = instr_valid && (r_state == ST_RUN) && !stall_in;
  assign w_is_mul     = w_dec.valid && (w_dec.alu_ctrl == 2'b10);

  // Next-state and next-pipeline-word logic; defaults hold everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ex_nxt       = r_ex;
    w_wb_valid_nxt = r_wb_valid;
    w_wb_we_nxt    = r_wb_we;
    w_flush_nxt    = 1'b0;
    w_illegal_nxt  = 1'b0;
    if (!stall_in) begin
      case (r_state)
        ST_RUN: begin
          w_wb_valid_nxt = r_ex.valid;
          w_wb_we_nxt    = r_ex.valid & r_ex.reg_write;
          if (w_accept) begin
            w_ex_nxt = w_dec;
            if (!w_dec.valid) begin
              w_illegal_nxt = 1'b1;
            end else if (w_is_mul) begin
              w_cnt_nxt   = 4'(MC_CYCLES - 1);
              w_state_nxt = ST_MUL;
            end else if (w_dec.jump) begin
              w_flush_nxt = 1'b1;
              w_state_nxt = ST_FLUSH;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_ex_nxt = C_BUBBLE;
          end
        end
        ST_MUL: begin
          if (r_cnt != 4'd0) begin
            // mul keeps EX; nothing reaches WB meanwhile.
            w_wb_valid_nxt = 1'b0;
            w_wb_we_nxt    = 1'b0;
            w_cnt_nxt      = r_cnt - 4'd1;
          end else begin
            w_wb_valid_nxt = r_ex.valid;
            w_wb_we_nxt    = r_ex.valid & r_ex.reg_write;
            w_ex_nxt       = C_BUBBLE;
            w_state_nxt    = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // The squashed decode slot enters EX as a bubble.
          w_wb_valid_nxt = r_ex.valid;
          w_wb_we_nxt    = r_ex.valid & r_ex.reg_write;
          w_ex_nxt       = C_BUBBLE;
          w_state_nxt    = ST_RUN;
        end
        default: begin
          w_wb_valid_nxt = 1'b0;
          w_wb_we_nxt    = 1'b0;
          w_ex_nxt       = C_BUBBLE;
          w_cnt_nxt      = 4'd0;
          w_state_nxt    = ST_RUN;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, counter and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_cnt      <= 4'd0;
      r_ex       <= C_BUBBLE;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_flush    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ex       <= w_ex_nxt;
      r_wb_valid <= w_wb_valid_nxt;
      r_wb_we    <= w_wb_we_nxt;
      r_flush    <= w_flush_nxt;
      r_illegal  <= w_illegal_nxt;
    end
  end

  assign ex_valid     = r_ex.valid;
  assign ex_alu_ctrl  = r_ex.alu_ctrl;
  assign ex_alu_src   = r_ex.alu_src;
  assign ex_imm_sel   = r_ex.imm_sel;
  assign ex_jump      = r_ex.jump;
  assign wb_valid     = r_wb_valid;
  assign wb_reg_write = r_wb_we;
  assign flush_id     = r_flush;
  assign illegal      = r_illegal;
  // Gated by rst_n so that every output reads 0 while reset is held.
  assign stall_out    = rst_n & (stall_in | (r_state == ST_MUL));

endmodule
